fuzz_stim_misr: RTL and testbench

Synthesizable, self-contained stimulus/response harness for generated-design equivalence runs.
- Drives a parametrised-width pseudo-random stimulus bus into a DUT `top`, one vector per clock.
- Can insert all-zero "gap" vectors between stimulus vectors.
- Compacts the DUT's wide output bus into a MISR signature, so the RTL and synthesised netlists are compared by one word instead of per-cycle dumps.
- Sits beside `top` inside the simulation/emulation wrapper, with a start/busy/done handshake to the run controller.

---
 rtl/fuzz_harness_pkg.sv | 39 +++
 rtl/fuzz_misr.sv | 34 +++
 rtl/fuzz_stim_misr.sv | 164 ++++++++++++++++
 tb/tb_fuzz_stim_misr.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_harness_pkg.sv
// Shared types and helpers for the fuzz stimulus/MISR harness.
package fuzz_harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;
  localparam logic [63:0] DEF_LFSR_TAPS = 64'hD800000000000000;

  // Upper bounds for the fold helper: response width and signature width.
  localparam int unsigned FOLD_IN_MAX  = 1024;
  localparam int unsigned FOLD_SIG_MAX = 64;

  // XOR of data[out_w-1:0] split into misr_w-bit chunks from bit 0; the
  // top partial chunk is implicitly zero-padded.
  function automatic logic [FOLD_SIG_MAX-1:0] fold(
    input logic [FOLD_IN_MAX-1:0] data,
    input int unsigned            out_w,
    input int unsigned            misr_w
  );
    logic [FOLD_SIG_MAX-1:0] acc;
    logic [5:0]              idx;
    acc = '0;
    idx = '0;
    for (int unsigned i = 0; i < FOLD_IN_MAX; i++) begin
      if (i < out_w && misr_w != 0) begin
        idx      = 6'(i % misr_w);
        acc[idx] = acc[idx] ^ data[10'(i)];
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Multiple-input signature register compacting a wide response bus.
module fuzz_misr
  import fuzz_harness_pkg::*;
#(
  parameter int unsigned       OUT_W     = 501,
  parameter int unsigned       MISR_W    = 32,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [OUT_W-1:0]  data,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_fold;

  assign w_fold = MISR_W'(fold(FOLD_IN_MAX'(data), OUT_W, MISR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= (r_sig << 1) ^ (r_sig[MISR_W-1] ? MISR_POLY : '0) ^ w_fold;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/fuzz_stim_misr.sv
// Stimulus/response harness: LFSR-driven stimulus bus with optional zero gaps,
// response compaction into a MISR signature, start/busy/done handshake.
module fuzz_stim_misr
  import fuzz_harness_pkg::*;
#(
  parameter int unsigned       IN_W      = 79,
  parameter int unsigned       OUT_W     = 501,
  parameter int unsigned       NUM_VEC   = 24,
  parameter int unsigned       RESP_LAT  = 1,
  parameter int unsigned       MISR_W    = 32,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY),
  parameter logic [63:0]       LFSR_TAPS = DEF_LFSR_TAPS,
  localparam int unsigned      CNT_W     = $clog2(NUM_VEC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              zero_gap_en,
  input  logic              seed_load,
  input  logic [63:0]       seed_in,
  output logic [IN_W-1:0]   stim,
  input  logic [OUT_W-1:0]  resp,
  output logic              busy,
  output logic              done,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  vec_count
);

  localparam int unsigned REP = (IN_W + 127) / 128;

  // IN_W LSBs of {.., ~l, l}, with l at bit 0.
  function automatic logic [IN_W-1:0] stim_pattern(input logic [63:0] l);
    return IN_W'({REP{~l, l}});
  endfunction

  function automatic logic [63:0] lfsr_adv(input logic [63:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
  endfunction

  state_t           r_state;
  logic [63:0]      r_lfsr;
  logic             r_gap_en;
  logic [CNT_W-1:0] r_vec_count;
  logic [IN_W-1:0]  r_stim;
  logic             r_busy;
  logic             r_done;

  logic [63:0] w_seed;
  logic [63:0] w_lfsr_start;
  logic [63:0] w_lfsr_next;
  logic        w_last;
  logic        w_valid_in;
  logic        w_clr;
  logic        w_cap_en;
  logic        w_pipe_drained;

  assign w_seed       = (seed_in == '0) ? 64'h1 : seed_in;
  assign w_lfsr_start = seed_load ? w_seed : r_lfsr;
  assign w_lfsr_next  = lfsr_adv(r_lfsr);
  assign w_last       = (32'(r_vec_count) + 32'd1) >= NUM_VEC;
  assign w_valid_in   = (r_state == ST_DRIVE) || (r_state == ST_GAP);
  assign w_clr        = (r_state == ST_IDLE) && start;

  // Valid delay line aligning capture with the DUT response latency.
  if (RESP_LAT == 0) begin : g_lat0
    assign w_cap_en       = w_valid_in;
    assign w_pipe_drained = 1'b1;
  end else begin : g_pipe
    logic [RESP_LAT-1:0] r_pipe;
    logic [RESP_LAT-1:0] w_shift;
    assign w_shift = r_pipe << 1;
    always_ff @(posedge clk) begin
      if (rst) r_pipe <= '0;
      else     r_pipe <= w_shift | RESP_LAT'(w_valid_in);
    end
    assign w_cap_en       = r_pipe[RESP_LAT-1];
    assign w_pipe_drained = (w_shift == '0);
  end

  // Outputs are registered alongside the state, so stim is loaded with the
  // pattern of the LFSR value the next DRIVE cycle will hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= 64'h1;
      r_gap_en    <= 1'b0;
      r_vec_count <= '0;
      r_stim      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (seed_load) r_lfsr <= w_seed;
          if (start) begin
            r_vec_count <= '0;
            r_gap_en    <= zero_gap_en;
            r_stim      <= stim_pattern(w_lfsr_start);
            r_busy      <= 1'b1;
            r_state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_lfsr <= w_lfsr_next;
          if (32'(r_vec_count) < NUM_VEC) r_vec_count <= r_vec_count + CNT_W'(1);
          if (w_last) begin
            r_stim <= '0;
            if (RESP_LAT == 0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_FLUSH;
            end
          end else if (r_gap_en) begin
            r_stim  <= '0;
            r_state <= ST_GAP;
          end else begin
            r_stim <= stim_pattern(w_lfsr_next);
          end
        end
        ST_GAP: begin
          r_stim  <= stim_pattern(r_lfsr);
          r_state <= ST_DRIVE;
        end
        ST_FLUSH: begin
          if (w_pipe_drained) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_stim  <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  fuzz_misr #(
    .OUT_W    (OUT_W),
    .MISR_W   (MISR_W),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_cap_en),
    .data(resp),
    .sig (signature)
  );

  assign stim      = r_stim;
  assign busy      = r_busy;
  assign done      = r_done;
  assign vec_count = r_vec_count;

endmodule

// File: tb/tb_fuzz_stim_misr.sv
// Directed bench for fuzz_stim_misr across four parameterisations.
module tb_fuzz_stim_misr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, zero_gap_en, seed_load;
  logic [63:0] seed_in;
  logic        start_a, start_b, start_c, start_d;

  // u_a: defaults, resp from a 1-cycle-latency model of the DUT.
  logic [78:0]  stim_a;
  logic [500:0] resp_a;
  logic         busy_a, done_a;
  logic [31:0]  sig_a;
  logic [4:0]   vc_a;
  // u_b: NUM_VEC=2
  logic [78:0]  stim_b;
  logic [500:0] resp_b;
  logic         busy_b, done_b;
  logic [31:0]  sig_b;
  logic [1:0]   vc_b;
  // u_c: OUT_W=32, NUM_VEC=2, RESP_LAT=0
  logic [78:0]  stim_c;
  logic [31:0]  resp_c;
  logic         busy_c, done_c;
  logic [31:0]  sig_c;
  logic [1:0]   vc_c;
  // u_d: NUM_VEC=3 (gap run)
  logic [78:0]  stim_d;
  logic [500:0] resp_d;
  logic         busy_d, done_d;
  logic [31:0]  sig_d;
  logic [1:0]   vc_d;

  always @(posedge clk) resp_a <= {stim_a, 343'b0, stim_a};

  fuzz_stim_misr u_a (
    .clk(clk), .rst(rst), .start(start_a), .zero_gap_en(zero_gap_en),
    .seed_load(seed_load), .seed_in(seed_in), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .signature(sig_a), .vec_count(vc_a));

  fuzz_stim_misr #(.NUM_VEC(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .zero_gap_en(zero_gap_en),
    .seed_load(seed_load), .seed_in(seed_in), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .signature(sig_b), .vec_count(vc_b));

  fuzz_stim_misr #(.OUT_W(32), .NUM_VEC(2), .RESP_LAT(0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .zero_gap_en(zero_gap_en),
    .seed_load(seed_load), .seed_in(seed_in), .stim(stim_c), .resp(resp_c),
    .busy(busy_c), .done(done_c), .signature(sig_c), .vec_count(vc_c));

  fuzz_stim_misr #(.NUM_VEC(3)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .zero_gap_en(zero_gap_en),
    .seed_load(seed_load), .seed_in(seed_in), .stim(stim_d), .resp(resp_d),
    .busy(busy_d), .done(done_d), .signature(sig_d), .vec_count(vc_d));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference signature for a 24-vector, no-gap run of u_a from the given seed.
  function automatic logic [31:0] model_sig(input logic [63:0] seed);
    logic [63:0]  l;
    logic [78:0]  s;
    logic [500:0] r;
    logic [31:0]  f, sig;
    l   = (seed == 64'd0) ? 64'd1 : seed;
    sig = '0;
    for (int k = 0; k < 24; k++) begin
      s = {~l[14:0], l};
      r = {s, 343'b0, s};
      f = '0;
      for (int b = 0; b < 501; b++) f[5'(b % 32)] = f[5'(b % 32)] ^ r[9'(b)];
      sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ f;
      l   = {1'b0, l[63:1]} ^ (l[0] ? 64'hD800000000000000 : 64'h0);
    end
    return sig;
  endfunction

  // One u_a run over a fixed 40-cycle window; optional reset and disturbances.
  task automatic run_a(input logic [63:0] seed, input int unsigned abort_at, input bit disturb,
                       output int unsigned done_cyc, output int unsigned n_done);
    done_cyc  = 0;
    n_done    = 0;
    seed_in   = seed;
    seed_load = 1'b1;
    start_a   = 1'b1;
    tick();
    seed_load = 1'b0;
    start_a   = 1'b0;
    for (int unsigned c = 1; c <= 40; c++) begin
      if (done_a) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (abort_at != 0 && c == abort_at + 1)
        check_eq("abort_busy", 512'(busy_a), 512'(0));
      start_a   = disturb && (c == 5);
      seed_load = disturb && (c == 8);
      seed_in   = (disturb && c == 8) ? 64'hFFFF0000FFFF0000 : seed;
      rst       = (c == abort_at);
      tick();
    end
    rst       = 1'b0;
    start_a   = 1'b0;
    seed_load = 1'b0;
  endtask

  logic [78:0]  exp_d [7];
  logic         exp_bd[7];
  int unsigned  dc, nd;
  logic [31:0]  ref_sig;

  initial begin
    rst = 1'b1; zero_gap_en = 1'b0; seed_load = 1'b0; seed_in = '0;
    start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; start_d = 1'b1;
    resp_b = '0; resp_c = 32'hFFFFFFFF; resp_d = '0;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("rst_stim%0d", i), 512'(stim_a), 512'(0));
      check_eq($sformatf("rst_busy%0d", i), 512'(busy_a), 512'(0));
      check_eq($sformatf("rst_done%0d", i), 512'(done_a), 512'(0));
      check_eq($sformatf("rst_sig%0d", i), 512'(sig_a), 512'(0));
    end
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    tick();
    check_eq("post_rst_stim", 512'(stim_a), 512'(0));
    check_eq("post_rst_busy", 512'(busy_a), 512'(0));
    check_eq("post_rst_vc", 512'(vc_a), 512'(0));
    check_eq("post_rst_sig", 512'(sig_a), 512'(0));

    // Seed 1 with start, NUM_VEC=2, RESP_LAT=1
    seed_in = 64'd1; seed_load = 1'b1; start_b = 1'b1;
    tick();
    seed_load = 1'b0; start_b = 1'b0;
    check_eq("seed_v0", 512'(stim_b), 512'({15'h7FFE, 64'h1}));
    check_eq("seed_busy1", 512'(busy_b), 512'(1));
    tick();
    check_eq("seed_v1", 512'(stim_b), 512'({15'h7FFF, 64'hD800000000000000}));
    check_eq("seed_vc2", 512'(vc_b), 512'(1));
    tick();
    check_eq("flush_stim", 512'(stim_b), 512'(0));
    check_eq("flush_busy", 512'(busy_b), 512'(1));
    check_eq("flush_done", 512'(done_b), 512'(0));
    tick();
    check_eq("done_c4", 512'(done_b), 512'(1));
    check_eq("done_busy", 512'(busy_b), 512'(0));
    check_eq("done_vc", 512'(vc_b), 512'(2));
    tick();
    check_eq("done_pulse_end", 512'(done_b), 512'(0));
    check_eq("sig_b_zero", 512'(sig_b), 512'(0));

    // Seed 0 replaced by 1
    seed_in = 64'd0; seed_load = 1'b1; start_b = 1'b1;
    tick();
    seed_load = 1'b0; start_b = 1'b0;
    check_eq("seed0_v0", 512'(stim_b), 512'({15'h7FFE, 64'h1}));
    for (int i = 0; i < 4; i++) tick();

    // OUT_W=32, resp all ones, RESP_LAT=0; LFSR=1 from idle seed loads above
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    check_eq("c_v0", 512'(stim_c), 512'({15'h7FFE, 64'h1}));
    check_eq("c_busy", 512'(busy_c), 512'(1));
    tick();
    check_eq("c_v1", 512'(stim_c), 512'({15'h7FFF, 64'hD800000000000000}));
    check_eq("c_sig1", 512'(sig_c), 512'(32'hFFFFFFFF));
    check_eq("c_done_early", 512'(done_c), 512'(0));
    tick();
    check_eq("c_done", 512'(done_c), 512'(1));
    check_eq("c_sig2", 512'(sig_c), 512'(32'h04C11DB6));
    check_eq("c_vc", 512'(vc_c), 512'(2));
    tick();
    check_eq("c_sig_hold", 512'(sig_c), 512'(32'h04C11DB6));

    // Gap run, NUM_VEC=3: V0,0,V1,0,V2,FLUSH,DONE
    exp_d[0] = {15'h7FFE, 64'h1};
    exp_d[1] = '0;
    exp_d[2] = {15'h7FFF, 64'hD800000000000000};
    exp_d[3] = '0;
    exp_d[4] = {15'h7FFF, 64'h6C00000000000000};
    exp_d[5] = '0;
    exp_d[6] = '0;
    exp_bd   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    seed_in = 64'd1; seed_load = 1'b1; zero_gap_en = 1'b1; start_d = 1'b1;
    tick();
    seed_load = 1'b0; zero_gap_en = 1'b0; start_d = 1'b0;
    for (int c = 0; c < 7; c++) begin
      check_eq($sformatf("gap_stim_c%0d", c + 1), 512'(stim_d), 512'(exp_d[c]));
      check_eq($sformatf("gap_busy_c%0d", c + 1), 512'(busy_d), 512'(exp_bd[c]));
      check_eq($sformatf("gap_done_c%0d", c + 1), 512'(done_d), 512'(c == 6));
      tick();
    end
    check_eq("gap_sig", 512'(sig_d), 512'(0));
    check_eq("gap_vc", 512'(vc_d), 512'(3));

    // Full-length runs on u_a against the reference model
    ref_sig = model_sig(64'h0123456789ABCDEF);
    run_a(64'h0123456789ABCDEF, 0, 1'b0, dc, nd);
    check_eq("clean_done_cyc", 512'(dc), 512'(26));
    check_eq("clean_ndone", 512'(nd), 512'(1));
    check_eq("clean_sig", 512'(sig_a), 512'(ref_sig));
    check_eq("clean_vc", 512'(vc_a), 512'(24));

    run_a(64'h0123456789ABCDEF, 3, 1'b0, dc, nd);
    check_eq("abort_ndone", 512'(nd), 512'(0));

    run_a(64'h0123456789ABCDEF, 0, 1'b0, dc, nd);
    check_eq("rerun_done_cyc", 512'(dc), 512'(26));
    check_eq("rerun_sig", 512'(sig_a), 512'(ref_sig));

    run_a(64'h0123456789ABCDEF, 0, 1'b1, dc, nd);
    check_eq("disturb_done_cyc", 512'(dc), 512'(26));
    check_eq("disturb_ndone", 512'(nd), 512'(1));
    check_eq("disturb_sig", 512'(sig_a), 512'(ref_sig));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
